avaliador_de_passos: RTL and testbench
======================================

AVALIADOR_DE_PASSOS -- requirements
Module: avaliador_de_passos

Interface
REQ-001 The module SHALL have parameter TICKS_POR_PASSO, default 25_000_000, clk cycles per step; legal range is 8 or more.
REQ-002 The module SHALL have parameter JANELA, default 12_500_000, the last step tick on which player input is accepted; legal range is 2 to TICKS_POR_PASSO-2.
REQ-003 The module SHALL have parameter PONTOS_BASE, default 10, the points awarded per hit before the combo bonus.
REQ-004 The module SHALL have port clk, input, 1 bit, the single system clock.
REQ-005 The module SHALL have port reset, input, 1 bit, asynchronous and active-high.
REQ-006 The module SHALL have port iniciar, input, 1 bit, a one-cycle start pulse.
REQ-007 The module SHALL have port prox_comando, input, 4 bits, the expected command from the pattern manager.
REQ-008 The module SHALL have port fim_de_jogo, input, 1 bit, the end flag from the pattern manager.
REQ-009 The module SHALL have port entrada_jogador, input, 4 bits, the debounced player command code.
REQ-010 The module SHALL have port entrada_valida, input, 1 bit, a one-cycle strobe qualifying entrada_jogador.
REQ-011 The module SHALL have port trocar_comando, output, 1 bit, the step strobe that drives the pattern manager's trocar_comando.
REQ-012 The module SHALL have port acerto, output, 1 bit, a one-cycle hit pulse.
REQ-013 The module SHALL have port erro, output, 1 bit, a one-cycle miss pulse.
REQ-014 The module SHALL have port pontuacao, output, 16 bits, the running score.
REQ-015 The module SHALL have port combo, output, 8 bits, the consecutive-hit count.
REQ-016 The module SHALL have port jogando, output, 1 bit, high while a game is running.

Function
REQ-017 The state machine SHALL have the states OCIOSO, AGUARDA, JULGADO and ENCERRADO.
REQ-018 Tick counter: 0 to TICKS_POR_PASSO-1, then wraps to 0, which starts a new step; the counter is active only outside OCIOSO and ENCERRADO.
REQ-019 trocar_comando: high for ticks 0 to TICKS_POR_PASSO/2-1 (a registered output) and low otherwise, including in OCIOSO and ENCERRADO.
REQ-020 On tick 2 of every step the block SHALL latch prox_comando into cmd_atual and sample fim_de_jogo.
REQ-021 If fim_de_jogo is high at tick 2: go to ENCERRADO with no judgement for that step.
REQ-022 OCIOSO to AGUARDA on iniciar: tick counter = 0, pontuacao = 0, combo = 0, jogando = 1.
REQ-023 AGUARDA: the first entrada_valida on ticks 2 to JANELA inclusive is judged; entrada_valida outside that window is ignored.
REQ-024 Match (entrada_jogador == cmd_atual, cmd_atual != 0): acerto pulse on the next cycle; pontuacao += PONTOS_BASE + combo, saturating at 0xFFFF; combo += 1, saturating at 255.
REQ-025 Mismatch: erro pulse on the next cycle; combo = 0; pontuacao unchanged.
REQ-026 Any judged input moves AGUARDA to JULGADO; further inputs in the same step are ignored.
REQ-027 No input by tick JANELA with cmd_atual != 0: erro pulse on tick JANELA+1; combo = 0.
REQ-028 cmd_atual == 0 (pause step): any input in the window is judged as erro; no input produces no pulse and combo is kept.
REQ-029 An entrada_valida on exactly tick JANELA SHALL be judged normally; tick JANELA+1 is outside the window.
REQ-030 A step wrap in JULGADO or AGUARDA SHALL return the machine to AGUARDA.
REQ-031 acerto and erro SHALL never be high in the same cycle.
REQ-032 ENCERRADO: jogando = 0; pontuacao and combo hold; iniciar restarts exactly as in REQ-022.
REQ-033 iniciar in AGUARDA or JULGADO SHALL be ignored.

Reset
REQ-034 Reset SHALL immediately force the state to OCIOSO, the tick counter to 0, cmd_atual to 0, and every output to 0.
REQ-035 Reset mid-step SHALL abort without emitting a pulse; the first clk edge after release SHALL see state OCIOSO.

Structure
REQ-036 The shared package SHALL hold the state encodings, COMANDO_PAUSA = 4'd0, and the score and combo widths.
REQ-037 Sub-module divisor_de_passo SHALL own the tick counter and generate the trocar_comando, amostra (tick 2) and fim_janela (tick JANELA+1) strobes.
REQ-038 The judge FSM and score datapath SHALL reside in avaliador_de_passos.

Verification
All scenarios use TICKS_POR_PASSO=8, JANELA=4, PONTOS_BASE=10.
REQ-039 Hit scenario: iniciar, prox_comando=1, input 1 at tick 3 -> acerto at tick 4, pontuacao=10, combo=1; second hit -> pontuacao=21, combo=2.
REQ-040 Mismatch and late-input scenario: input 7 vs command 1 -> erro, combo=0; input at tick 5 -> ignored, erro at tick 5 from the timeout.
REQ-041 Pause-step scenario: command 0 with no input -> no pulse and combo kept; command 0 with input 3 -> erro and combo=0.
REQ-042 Window-edge scenario: input at tick 4 -> judged; two inputs in one step -> only the first judged.
REQ-043 End and restart scenario: fim_de_jogo high at tick 2 -> ENCERRADO, jogando=0, score held; iniciar -> pontuacao=0, jogando=1.
REQ-044 Reset scenario: assert reset at tick 3 of an AGUARDA step -> all outputs 0 asynchronously, with no acerto or erro pulse.

Source files
------------

// File: rtl/avaliador_de_passos_pkg.sv
// avaliador_de_passos_pkg: shared judge state encodings, pause command and datapath widths
package avaliador_de_passos_pkg;
   typedef enum logic [1:0] {OCIOSO, AGUARDA, JULGADO, ENCERRADO} estado_t;
   localparam logic [3:0] COMANDO_PAUSA = 4'd0;
   localparam int LARG_PONTOS = 16;
   localparam int LARG_COMBO = 8;
endpackage

// File: rtl/avaliador_de_passos_divisor_de_passo.sv
// divisor_de_passo: step tick counter with step strobe, sample strobe and window strobes
module divisor_de_passo #(
   parameter int TICKS_POR_PASSO = 25_000_000,
   parameter int JANELA = 12_500_000
) (
   input  logic clk,
   input  logic reset,
   input  logic ativo,
   input  logic inicio,
   output logic trocar_comando,
   output logic amostra,
   output logic na_janela,
   output logic fim_janela,
   output logic virada
);
   localparam int W = $clog2(TICKS_POR_PASSO);
   logic [W-1:0] tick, tick_n;
   // ativo is the judge's next-state activity, so trocar_comando lines up with tick
   always_comb tick_n = (!ativo || inicio || virada) ? '0 : tick + 1'b1;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         tick <= '0;
         trocar_comando <= 1'b0;
      end else begin
         tick <= tick_n;
         trocar_comando <= ativo && tick_n < W'(TICKS_POR_PASSO / 2);
      end
   assign virada = tick == W'(TICKS_POR_PASSO - 1);
   assign amostra = tick == W'(2);
   assign na_janela = tick >= W'(2) && tick <= W'(JANELA);
   assign fim_janela = tick == W'(JANELA + 1);
endmodule

// File: rtl/avaliador_de_passos.sv
// avaliador_de_passos: judges player input against the expected command each step and keeps score
module avaliador_de_passos
   import avaliador_de_passos_pkg::*;
#(
   parameter int TICKS_POR_PASSO = 25_000_000,
   parameter int JANELA = 12_500_000,
   parameter int PONTOS_BASE = 10
) (
   input  logic clk,
   input  logic reset,
   input  logic iniciar,
   input  logic [3:0] prox_comando,
   input  logic fim_de_jogo,
   input  logic [3:0] entrada_jogador,
   input  logic entrada_valida,
   output logic trocar_comando,
   output logic acerto,
   output logic erro,
   output logic [LARG_PONTOS-1:0] pontuacao,
   output logic [LARG_COMBO-1:0] combo,
   output logic jogando
);
   estado_t estado, estado_n;
   logic [3:0] cmd_atual, cmd_ef;
   logic amostra, na_janela, fim_janela, virada;
   logic em_passo, inicio, encerra, julga, acerta, expira, acerto_r, erro_r;
   logic [LARG_PONTOS:0] soma;
   divisor_de_passo #(
      .TICKS_POR_PASSO(TICKS_POR_PASSO),
      .JANELA(JANELA)
   ) u_divisor (
      .clk(clk),
      .reset(reset),
      .ativo(estado_n == AGUARDA || estado_n == JULGADO),
      .inicio(inicio),
      .trocar_comando(trocar_comando),
      .amostra(amostra),
      .na_janela(na_janela),
      .fim_janela(fim_janela),
      .virada(virada)
   );
   assign em_passo = estado == AGUARDA || estado == JULGADO;
   assign inicio = iniciar && !em_passo;
   assign encerra = em_passo && amostra && fim_de_jogo;
   // an input on tick 2 must see the command being latched in that same cycle
   assign cmd_ef = amostra ? prox_comando : cmd_atual;
   assign julga = estado == AGUARDA && entrada_valida && na_janela && !encerra;
   assign acerta = julga && entrada_jogador == cmd_ef && cmd_ef != COMANDO_PAUSA;
   assign expira = estado == AGUARDA && fim_janela && cmd_atual != COMANDO_PAUSA;
   assign soma = {1'b0, pontuacao} + (LARG_PONTOS + 1)'(PONTOS_BASE)
               + {{(LARG_PONTOS + 1 - LARG_COMBO){1'b0}}, combo};
   always_comb
      estado_n = inicio ? AGUARDA
               : encerra ? ENCERRADO
               : julga ? JULGADO
               : (virada && estado == JULGADO) ? AGUARDA
               : estado;
   always_ff @(posedge clk or posedge reset)
      if (reset) estado <= OCIOSO;
      else estado <= estado_n;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         cmd_atual <= COMANDO_PAUSA;
         pontuacao <= '0;
         combo <= '0;
         acerto_r <= 1'b0;
         erro_r <= 1'b0;
      end else begin
         cmd_atual <= (em_passo && amostra) ? prox_comando : inicio ? COMANDO_PAUSA : cmd_atual;
         pontuacao <= inicio ? '0 : acerta ? (soma[LARG_PONTOS] ? '1 : soma[LARG_PONTOS-1:0]) : pontuacao;
         combo <= (inicio || (julga && !acerta) || expira) ? '0
                : acerta ? (&combo ? combo : combo + 1'b1)
                : combo;
         acerto_r <= acerta;
         erro_r <= julga && !acerta;
      end
   // the timeout miss shows on tick JANELA+1 itself, decoded from registered state
   assign acerto = acerto_r;
   assign erro = erro_r || expira;
   assign jogando = em_passo;
endmodule

// File: tb/tb_avaliador_de_passos.sv
// tb_avaliador_de_passos: directed and random steps checked against a per-step rule model
module tb_avaliador_de_passos;
   localparam int T = 8;
   localparam int J = 4;
   localparam int P = 10;
   logic clk = 0, reset = 1, iniciar = 0, fim_de_jogo = 0, entrada_valida = 0;
   logic [3:0] prox_comando = 0, entrada_jogador = 0;
   logic trocar_comando, acerto, erro, jogando;
   logic [15:0] pontuacao;
   logic [7:0] combo;
   int compared = 0, mismatched = 0;
   int es = 0, ec = 0;
   bit ea = 0, ee = 0, em_jogo = 0;

   avaliador_de_passos #(.TICKS_POR_PASSO(T), .JANELA(J), .PONTOS_BASE(P)) dut (
      .clk(clk), .reset(reset), .iniciar(iniciar), .prox_comando(prox_comando),
      .fim_de_jogo(fim_de_jogo), .entrada_jogador(entrada_jogador), .entrada_valida(entrada_valida),
      .trocar_comando(trocar_comando), .acerto(acerto), .erro(erro),
      .pontuacao(pontuacao), .combo(combo), .jogando(jogando)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      compared++;
      assert (obs === exp_v) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp_v, $time);
      end
   endtask

   task automatic chk_todos(input string tag, input bit jog, input bit troca);
      chk({tag, ".trocar"}, trocar_comando, troca);
      chk({tag, ".jogando"}, jogando, jog);
      chk({tag, ".acerto"}, acerto, 0);
      chk({tag, ".erro"}, erro, 0);
      chk({tag, ".pontuacao"}, pontuacao, es);
      chk({tag, ".combo"}, combo, ec);
   endtask

   task automatic comecar();
      iniciar = 1;
      @(posedge clk); #1;
      iniciar = 0;
      es = 0; ec = 0; ea = 0; ee = 0; em_jogo = 1;
   endtask

   // one full step: first in-window input is judged, timeout misses on J+1, pause steps never time out
   task automatic passo(input logic [3:0] cmd, input bit fim, input int t1, input logic [3:0] v1,
                        input int t2, input logic [3:0] v2, input int t_ini);
      bit julgado, limite, vale;
      logic [3:0] val;
      julgado = 0;
      for (int k = 0; k < T; k++) begin
         limite = em_jogo && !julgado && cmd != 0 && k == J + 1;
         chk("trocar", trocar_comando, em_jogo && k < T / 2);
         chk("jogando", jogando, em_jogo);
         chk("acerto", acerto, ea);
         chk("erro", erro, ee || limite);
         chk("pontuacao", pontuacao, es);
         chk("combo", combo, ec);
         vale = k == t1 || k == t2;
         val = k == t1 ? v1 : k == t2 ? v2 : 4'($urandom_range(0, 15));
         prox_comando = cmd;
         fim_de_jogo = fim;
         entrada_valida = vale;
         entrada_jogador = val;
         iniciar = k == t_ini;
         ea = 0;
         ee = 0;
         if (limite) ec = 0;
         if (em_jogo && k == 2 && fim) em_jogo = 0;
         else if (em_jogo && vale && !julgado && k >= 2 && k <= J) begin
            julgado = 1;
            if (cmd != 0 && val == cmd) begin
               ea = 1;
               es = (es + P + ec > 65535) ? 65535 : es + P + ec;
               ec = (ec == 255) ? 255 : ec + 1;
            end else begin
               ee = 1;
               ec = 0;
            end
         end
         @(posedge clk); #1;
      end
      entrada_valida = 0;
      iniciar = 0;
      fim_de_jogo = 0;
   endtask

   task automatic ocioso(input int n);
      for (int i = 0; i < n; i++) begin
         chk_todos("encerrado", 0, 0);
         entrada_valida = 1;
         entrada_jogador = 4'($urandom_range(0, 15));
         prox_comando = 4'($urandom_range(1, 15));
         @(posedge clk); #1;
      end
      entrada_valida = 0;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk_todos("reset", 0, 0);
      reset = 0;
      @(posedge clk); #1;
      chk_todos("ocioso", 0, 0);
      comecar();
      passo(1, 0, 3, 1, -1, 0, -1);
      passo(1, 0, 3, 1, -1, 0, -1);
      chk("hit2.pontuacao", pontuacao, 21);
      chk("hit2.combo", combo, 2);
      passo(1, 0, 3, 7, -1, 0, -1);
      passo(1, 0, 5, 1, -1, 0, -1);
      passo(2, 0, 3, 2, -1, 0, -1);
      passo(0, 0, -1, 0, -1, 0, -1);
      passo(0, 0, 3, 3, -1, 0, -1);
      passo(3, 0, 4, 3, -1, 0, -1);
      passo(2, 0, 2, 2, 3, 5, -1);
      passo(2, 0, 3, 9, 4, 2, -1);
      passo(1, 0, 3, 1, -1, 0, 3);
      passo(1, 0, -1, 0, -1, 0, 6);
      for (int s = 0; s < 40; s++)
         passo(4'($urandom_range(0, 3)), 0, int'($urandom_range(0, 7)), 4'($urandom_range(0, 3)),
               ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 7)) : -1, 4'($urandom_range(0, 3)),
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1);
      passo(1, 0, 3, 1, -1, 0, -1);
      passo(1, 1, 2, 1, 3, 1, -1);
      ocioso(6);
      comecar();
      chk("restart.pontuacao", pontuacao, 0);
      chk("restart.jogando", jogando, 1);
      passo(5, 0, 4, 5, -1, 0, -1);
      passo(5, 0, 3, 5, -1, 0, -1);
      prox_comando = 1;
      repeat (3) begin
         @(posedge clk); #1;
      end
      entrada_valida = 1;
      entrada_jogador = 1;
      #2 reset = 1;
      #1;
      es = 0; ec = 0;
      chk_todos("async_reset", 0, 0);
      @(posedge clk); #1;
      entrada_valida = 0;
      chk_todos("reset_held", 0, 0);
      reset = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         chk_todos("pos_reset", 0, 0);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
